e_mdu: RTL and testbench

- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Sits beside the ALU, upstream of the Memory stage.
- Owns the HI/LO registers and models multi-cycle mult/div latency with a busy counter.
- Its read port supplies mfhi/mflo results into the E/M pipeline register, i.e. the value that becomes m_aluout downstream.

---
 rtl/e_mdu.sv | 181 ++++++++++++++++++
 tb/tb_e_mdu.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
// Owns HI/LO, computes the 64-bit result at the launch edge into a pending
// register, and commits it to HI/LO after MULT_CYCLES/DIV_CYCLES.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu (ops 9-12).
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        e_start,
   input  logic [3:0]  e_mdu_op,
   input  logic [31:0] e_rs_val,
   input  logic [31:0] e_rt_val,
   output logic        e_busy,
   output logic        e_md_stall,
   output logic [31:0] e_hi,
   output logic [31:0] e_lo,
   output logic [31:0] e_mdu_out
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    hi_q, hi_d;
   logic [31:0]    lo_q, lo_d;
   logic [63:0]    pend_q, pend_d;

   mdu_op_e        op;
   logic           is_mul, is_div, is_acc, launch_op, md_class, launch;
   logic           sgn;
   logic [63:0]    ext_a, ext_b, prod;
   logic           a_neg, b_neg;
   logic [31:0]    a_mag, b_mag, q_mag, r_mag, quot, rem;
   logic [63:0]    result;

   assign op = mdu_op_e'(e_mdu_op);

   // Decode the E-stage op into launch / md-class / signedness
   always_comb begin
      is_mul = op inside {OP_MULT, OP_MULTU};
      is_div = op inside {OP_DIV, OP_DIVU};
`ifdef MDU_MADD_EN
      is_acc = op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
      is_acc = 1'b0;
`endif
      launch_op = is_mul | is_div | is_acc;
      md_class  = launch_op | (op inside {OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO});
      launch    = e_start && (state_q == ST_IDLE) && launch_op;
      sgn       = op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
   end

   // Arithmetic: one 64x64 multiply of extended operands covers signed and
   // unsigned products; division works on magnitudes so the most-negative
   // dividend never overflows, then the signs are reapplied.
   always_comb begin
      ext_a = {{32{sgn & e_rs_val[31]}}, e_rs_val};
      ext_b = {{32{sgn & e_rt_val[31]}}, e_rt_val};
      prod  = ext_a * ext_b;

      a_neg = sgn & e_rs_val[31];
      b_neg = sgn & e_rt_val[31];
      a_mag = a_neg ? (32'd0 - e_rs_val) : e_rs_val;
      b_mag = b_neg ? (32'd0 - e_rt_val) : e_rt_val;
      q_mag = '0;
      r_mag = '0;
      if (b_mag != '0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem  = a_neg ? (32'd0 - r_mag) : r_mag;

      // Divide by zero keeps the current HI/LO as the pending value
      result = {hi_q, lo_q};
      if (is_mul) begin
         result = prod;
      end else if (is_div) begin
         if (e_rt_val != '0) begin
            result = {rem, quot};
         end
      end
`ifdef MDU_MADD_EN
      else if (is_acc) begin
         if (op inside {OP_MADD, OP_MADDU}) begin
            result = {hi_q, lo_q} + prod;
         end else begin
            result = {hi_q, lo_q} - prod;
         end
      end
`endif
   end

   // Next-state: launch, countdown, commit, and mthi/mtlo while idle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      pend_d  = pend_q;
      case (state_q)
         ST_IDLE: begin
            if (launch) begin
               pend_d  = result;
               cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
               state_d = ST_BUSY;
            end else if (op == OP_MTHI) begin
               hi_d = e_rs_val;
            end else if (op == OP_MTLO) begin
               lo_d = e_rs_val;
            end
         end
         ST_BUSY: begin
            if (cnt_q == CW'(1)) begin
               hi_d    = pend_q[63:32];
               lo_d    = pend_q[31:0];
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pend_q  <= pend_d;
      end
   end

   // Outputs: busy/HI/LO from registers, stall and mfhi/mflo read combinational
   always_comb begin
      e_busy     = (state_q == ST_BUSY);
      e_hi       = hi_q;
      e_lo       = lo_q;
      e_md_stall = (e_busy || (e_start && launch_op)) && md_class;
      case (op)
         OP_MFHI: e_mdu_out = hi_q;
         OP_MFLO: e_mdu_out = lo_q;
         default: e_mdu_out = '0;
      endcase
   end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu. Expected HI/LO results are computed
// with 64-bit integer arithmetic and queued at launch; a monitor pops and
// compares when e_busy falls. Honours MDU_MADD_EN for ops 9-12.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic        e_start;
   logic [3:0]  e_mdu_op;
   logic [31:0] e_rs_val, e_rt_val;
   logic        e_busy, e_md_stall;
   logic [31:0] e_hi, e_lo, e_mdu_out;

   always #5 clk = ~clk;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .e_start(e_start), .e_mdu_op(e_mdu_op),
      .e_rs_val(e_rs_val), .e_rt_val(e_rt_val), .e_busy(e_busy),
      .e_md_stall(e_md_stall), .e_hi(e_hi), .e_lo(e_lo), .e_mdu_out(e_mdu_out)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_hi, m_lo;
   bit          en_acc;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Reference model: plain 64-bit integer arithmetic on the architectural rules
   function automatic logic [63:0] ref_op(input int op, input logic [31:0] rs, input logic [31:0] rt,
                                          input logic [31:0] hi, input logic [31:0] lo);
      longint          sa, sb_;
      longint unsigned ua, ub;
      sa  = $signed(rs);
      sb_ = $signed(rt);
      ua  = rs;
      ub  = rt;
      case (op)
         1: return sa * sb_;
         2: return ua * ub;
         3: if (rt == 0) return {hi, lo}; else return {32'(sa % sb_), 32'(sa / sb_)};
         4: if (rt == 0) return {hi, lo}; else return {32'(ua % ub), 32'(ua / ub)};
         9: return {hi, lo} + 64'(sa * sb_);
         10: return {hi, lo} + 64'(ua * ub);
         11: return {hi, lo} - 64'(sa * sb_);
         12: return {hi, lo} - 64'(ua * ub);
         default: return {hi, lo};
      endcase
   endfunction

   function automatic bit is_launch_op(input int op);
      return (op >= 1 && op <= 4) || (en_acc && op >= 9 && op <= 12);
   endfunction

   // Push expected result for a launch and advance the model
   task automatic push_exp(input int op, input logic [31:0] rs, input logic [31:0] rt, input string name);
      logic [63:0] r;
      exp_t        e;
      r        = ref_op(op, rs, rt, m_hi, m_lo);
      e.hi     = r[63:32];
      e.lo     = r[31:0];
      e.cycles = (op == 3 || op == 4) ? 10 : 5;
      e.name   = name;
      sb.push_back(e);
      m_hi = r[63:32];
      m_lo = r[31:0];
   endtask

   // Monitor: count busy cycles, compare on each falling edge of e_busy
   initial begin
      int   bcnt;
      logic prev;
      exp_t e;
      bcnt = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (e_busy === 1'b1) begin
            bcnt++;
         end else begin
            if (prev === 1'b1) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_completion: got busy fall expected none");
               end else begin
                  e = sb.pop_front();
                  if (reset === 1'b1) begin
                     chk({e.name, " reset_hi"}, e_hi, 0);
                     chk({e.name, " reset_lo"}, e_lo, 0);
                  end else begin
                     chk({e.name, " hi"}, e_hi, e.hi);
                     chk({e.name, " lo"}, e_lo, e.lo);
                     chk({e.name, " busy_cycles"}, bcnt, e.cycles);
                  end
               end
            end
            bcnt = 0;
         end
         prev = e_busy;
      end
   end

   task automatic wait_idle(input string name);
      bit done;
      done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (e_busy === 1'b0) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: got busy stuck expected idle within 40 cycles", name);
      end
   endtask

   task automatic launch(input int op, input logic [31:0] rs, input logic [31:0] rt, input string name);
      bit il;
      il = is_launch_op(op);
      @(posedge clk); #1;
      e_start = 1'b1; e_mdu_op = 4'(op); e_rs_val = rs; e_rt_val = rt;
      if (il) push_exp(op, rs, rt, name);
      @(negedge clk);
      chk({name, " stall"}, e_md_stall, il);
      @(posedge clk); #1;
      e_start = 1'b0; e_mdu_op = 4'd0;
      if (il) begin
         wait_idle(name);
      end else begin
         @(negedge clk);
         chk({name, " nop_busy"}, e_busy, 0);
         chk({name, " nop_hilo"}, {e_hi, e_lo}, {m_hi, m_lo});
      end
   endtask

   task automatic move_to(input int op, input logic [31:0] rs);
      @(posedge clk); #1;
      e_start = 1'b0; e_mdu_op = 4'(op); e_rs_val = rs;
      @(negedge clk);
      chk("mt_stall", e_md_stall, 0);
      @(posedge clk); #1;
      e_mdu_op = 4'd0;
      if (op == 5) m_hi = rs; else m_lo = rs;
      @(negedge clk);
      chk("mt_busy", e_busy, 0);
      chk("mt_hilo", {e_hi, e_lo}, {m_hi, m_lo});
   endtask

   task automatic read_out();
      @(posedge clk); #1; e_mdu_op = 4'd7;
      @(negedge clk);
      chk("mfhi_out", e_mdu_out, m_hi);
      chk("mfhi_stall", e_md_stall, 0);
      @(posedge clk); #1; e_mdu_op = 4'd8;
      @(negedge clk);
      chk("mflo_out", e_mdu_out, m_lo);
      @(posedge clk); #1; e_mdu_op = 4'd0;
      @(negedge clk);
      chk("nop_out", e_mdu_out, 0);
   endtask

   initial begin
      logic [31:0] old_hi, rs, rt;
      int          op, k;
`ifdef MDU_MADD_EN
      en_acc = 1;
`else
      en_acc = 0;
`endif
      reset = 1'b1; e_start = 1'b0; e_mdu_op = 4'd0; e_rs_val = '0; e_rt_val = '0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_hilo", {e_hi, e_lo}, 64'd0);
      chk("reset_busy", e_busy, 0);
      chk("reset_stall", e_md_stall, 0);

      launch(1, 32'hFFFFFFFF, 32'd2, "mult");
      read_out();
      launch(2, 32'hFFFFFFFF, 32'd2, "multu");
      read_out();
      launch(3, 32'hFFFFFFF9, 32'd2, "div");
      read_out();
      move_to(5, 32'h11);
      move_to(6, 32'h22);
      launch(4, 32'd7, 32'd0, "divu_by_zero");
      read_out();
      launch(3, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
      read_out();
      move_to(5, 32'hAAAA5555);

      // mthi during a divide is ignored and stalls
      @(posedge clk); #1;
      e_start = 1'b1; e_mdu_op = 4'd3; e_rs_val = 32'd100; e_rt_val = 32'd7;
      old_hi = m_hi;
      push_exp(3, 32'd100, 32'd7, "div_mthi");
      @(posedge clk); #1;
      e_start = 1'b0; e_mdu_op = 4'd5; e_rs_val = 32'h12345678;
      @(negedge clk);
      chk("mthi_busy_stall", e_md_stall, 1);
      @(posedge clk); #1; e_mdu_op = 4'd0;
      @(negedge clk);
      chk("mthi_busy_hi", e_hi, old_hi);
      wait_idle("div_mthi");

      // start while busy is ignored
      @(posedge clk); #1;
      e_start = 1'b1; e_mdu_op = 4'd1; e_rs_val = 32'd12345; e_rt_val = 32'hFFFFFF00;
      push_exp(1, 32'd12345, 32'hFFFFFF00, "mult_restart");
      @(posedge clk); #1;
      e_mdu_op = 4'd4; e_rs_val = 32'd9; e_rt_val = 32'd1;
      @(negedge clk);
      chk("restart_stall", e_md_stall, 1);
      @(posedge clk); #1;
      e_start = 1'b0; e_mdu_op = 4'd0;
      wait_idle("mult_restart");
      read_out();

      // madd accumulate (nop when the feature is absent)
      move_to(5, 32'h0);
      move_to(6, 32'hFFFFFFFF);
      launch(9, 32'd1, 32'd1, "madd");
      read_out();

      // reset at busy cycle 4 of a divide discards the result
      @(posedge clk); #1;
      e_start = 1'b1; e_mdu_op = 4'd3; e_rs_val = 32'd50; e_rt_val = 32'd3;
      push_exp(3, 32'd50, 32'd3, "div_reset");
      @(posedge clk); #1;
      e_start = 1'b0; e_mdu_op = 4'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      m_hi = '0; m_lo = '0;
      @(posedge clk);
      @(posedge clk); #1 reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("post_reset_busy", e_busy, 0);
      chk("post_reset_hilo", {e_hi, e_lo}, 64'd0);

      // randomized mix
      for (int i = 0; i < 40; i++) begin
         k  = $urandom_range(0, 9);
         op = (k < 8) ? (k % 6) + 1 : $urandom_range(9, 12);
         rs = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         k  = $urandom_range(0, 7);
         rt = (k == 0) ? 32'd0 : (k == 1) ? 32'hFFFFFFFF : $urandom;
         if (op == 5 || op == 6) move_to(op, rs);
         else launch(op, rs, rt, $sformatf("rand%0d_op%0d", i, op));
         read_out();
      end

      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
